// File: rtl/keypad_debounce.sv
// Conditions a raw active-low 10-key keypad into clean one-cycle digit events:
// 2-flop synchroniser, single/multi-key decode, press/release debounce, optional auto-repeat.
module keypad_debounce #(
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DLY   = 500,
  parameter int REPEAT_RATE  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       key_err
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_SAT   = DEB_W'(DEBOUNCE_CYC);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE - 1);
  localparam logic [REP_W-1:0] REP_SAT   = REP_W'(REP_MAX);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DEB = 3'd1,
    HELD      = 3'd2,
    REL_DEB   = 3'd3,
    LOCKOUT   = 3'd4
  } state_t;

  logic [9:0]       sync1_q, sync1_d;
  logic [9:0]       sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_err_q, key_err_d;

  logic [1:0]       low_cnt;
  logic [3:0]       low_idx;
  logic             is_none;
  logic             is_single;
  logic             is_multi;
  logic             same_key;
  logic [DEB_W-1:0] deb_inc;
  logic [REP_W-1:0] rep_inc;
  logic [REP_W-1:0] rep_target;

  assign sync1_d = keypad;
  assign sync2_d = sync1_q;

  // Decode the synchronised lines; low_cnt saturates at 2 meaning "two or more".
  always_comb begin
    low_cnt = 2'd0;
    low_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (!sync2_q[i]) begin
        low_idx = 4'(i);
        if (low_cnt != 2'd2) begin
          low_cnt = low_cnt + 2'd1;
        end
      end
    end
  end

  assign is_none    = (low_cnt == 2'd0);
  assign is_single  = (low_cnt == 2'd1);
  assign is_multi   = (low_cnt == 2'd2);
  assign same_key   = is_single && (low_idx == cand_q);
  assign deb_inc    = (deb_cnt_q == DEB_SAT) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);
  assign rep_inc    = (rep_cnt_q == REP_SAT) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
  assign rep_target = rep_first_q ? REP_FIRST : REP_NEXT;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    deb_cnt_d   = deb_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_err_d   = 1'b0;

    if (is_multi) begin
      // Multi-key overrides every state; the error pulses only on entry.
      state_d   = LOCKOUT;
      deb_cnt_d = '0;
      if (state_q != LOCKOUT) begin
        key_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d    = low_idx;
            deb_cnt_d = DEB_W'(1);
            state_d   = PRESS_DEB;
          end
        end

        PRESS_DEB: begin
          if (same_key) begin
            deb_cnt_d = deb_inc;
            if (deb_cnt_q >= DEB_LAST) begin
              key_valid_d = 1'b1;
              key_code_d  = cand_q;
              rep_cnt_d   = '0;
              rep_first_d = 1'b1;
              state_d     = HELD;
            end
          end else begin
            deb_cnt_d = '0;
            state_d   = IDLE;
          end
        end

        HELD: begin
          if (same_key) begin
            if (REPEAT_EN != 0) begin
              if (rep_cnt_q == rep_target) begin
                key_valid_d = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
              end else begin
                rep_cnt_d = rep_inc;
              end
            end
          end else begin
            state_d   = REL_DEB;
            deb_cnt_d = is_none ? DEB_W'(1) : '0;
          end
        end

        REL_DEB: begin
          if (is_none) begin
            deb_cnt_d = deb_inc;
            if (deb_cnt_q >= DEB_LAST) begin
              deb_cnt_d = '0;
              state_d   = IDLE;
            end
          end else if (same_key) begin
            // A bounce back onto the same key resumes the hold without a new event.
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
            state_d     = HELD;
          end else begin
            deb_cnt_d = '0;
          end
        end

        LOCKOUT: begin
          if (is_none) begin
            deb_cnt_d = deb_inc;
            if (deb_cnt_q >= DEB_LAST) begin
              deb_cnt_d = '0;
              state_d   = IDLE;
            end
          end else begin
            deb_cnt_d = '0;
          end
        end

        default: begin
          deb_cnt_d = '0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 10'h3FF;
      sync2_q     <= 10'h3FF;
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_err_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_err_q   <= key_err_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_err   = key_err_q;
  assign key_held  = (state_q == HELD) || (state_q == REL_DEB);

endmodule

// File: doc/keypad_debounce.md
Name: keypad_debounce

Overview:
- Upstream front end for the watch time-setting path. Conditions the raw active-low 10-key keypad (index 0..9 = digit 0..9) into clean one-cycle digit events.
- Synchronises, debounces and validates the raw lines. Rejects multi-key presses. Emits exactly one key_valid pulse per physical press, plus optional hold auto-repeat.
- Runs on the same 1 kHz system clock as the watch, so 1 cycle = 1 ms.

Parameters:
- DEBOUNCE_CYC, 20: consecutive stable samples required to accept a press or a release (min 2).
- REPEAT_EN, 0: 1 enables auto-repeat while a key is held.
- REPEAT_DLY, 500: cycles from the initial key_valid to the first repeat pulse.
- REPEAT_RATE, 200: cycles between subsequent repeat pulses.

Ports:
- clk  in  1  system clock, 1 kHz.
- rst  in  1  reset, synchronous, active-high.
- keypad  in  10  raw keypad lines, active-low; bit k low = digit k pressed; all-ones = no key.
- key_valid  out  1  one-cycle pulse: new digit (or repeat) on key_code.
- key_code  out  4  digit 0..9 of the last accepted event; holds between pulses.
- key_held  out  1  high while an accepted key is down (states HELD and REL_DEB).
- key_err  out  1  one-cycle pulse when a multi-key condition is detected.

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset rst is synchronous and active-high.
  - All state updates on posedge clk. rst has priority over everything.
- Reset values:
  - key_valid=0, key_code=0, key_held=0, key_err=0.
  - FSM=IDLE; all counters=0.
  - Both sync stages = 10'h3FF.
- Synchroniser: 2-flop synchroniser on keypad; the FSM sees only the second stage (ks).
- Decode of ks, combinational:
  - NONE: all ones.
  - SINGLE(k): exactly one bit low, k = its index.
  - MULTI: two or more bits low.
- FSM states: IDLE, PRESS_DEB, HELD, REL_DEB, LOCKOUT.
- MULTI in any state:
  - Go to LOCKOUT and pulse key_err for 1 cycle on entry (no further key_err while already in LOCKOUT).
  - Drop key_held. No key_valid.
- IDLE:
  - SINGLE(k): latch cand=k, deb_cnt=1, go to PRESS_DEB.
  - NONE: stay.
- PRESS_DEB:
  - ks==SINGLE(cand): deb_cnt++. When deb_cnt reaches DEBOUNCE_CYC, pulse key_valid, load key_code=cand, reset rep_cnt=0, go to HELD.
  - NONE or SINGLE(other): back to IDLE, no pulse.
- HELD:
  - key_held=1.
  - ks != SINGLE(cand): go to REL_DEB with deb_cnt=1 if NONE, else deb_cnt=0.
  - If REPEAT_EN: rep_cnt increments each cycle. Pulse key_valid (same key_code) when rep_cnt reaches REPEAT_DLY-1, then every REPEAT_RATE cycles thereafter.
- REL_DEB:
  - key_held stays 1.
  - ks==NONE: deb_cnt++. Reaching DEBOUNCE_CYC goes to IDLE.
  - ks==SINGLE(cand): return to HELD with rep_cnt=0 and no new pulse. A bounce never produces a second press.
  - ks==SINGLE(other): deb_cnt=0 and stay. The key must be released cleanly before a new key is accepted.
- LOCKOUT:
  - ks==NONE for DEBOUNCE_CYC consecutive cycles: go to IDLE.
  - Any non-NONE restarts the count.
- Latency:
  - Take a key applied to the pins and stable before edge E0.
  - key_valid is high in the cycle after edge E0+DEBOUNCE_CYC+1: 2 sync edges, then DEBOUNCE_CYC FSM samples.
- Pulse rules:
  - key_valid and key_err are never high simultaneously.
  - key_valid is never high on consecutive cycles, since REPEAT_RATE must be ≥2.
- Reset mid-operation:
  - Abort to IDLE with no pulse.
  - A key still held through reset is re-accepted as a fresh press after the full latency.
- Counter widths:
  - deb_cnt is sized by $clog2(DEBOUNCE_CYC+1).
  - rep_cnt is sized by $clog2(max(REPEAT_DLY,REPEAT_RATE)+1).
  - Counters saturate. No wrap in any state.

Test Plan:
- Clean press, DEBOUNCE_CYC=4, REPEAT_EN=0: hold keypad=10'b11_1111_0111 (digit 3) for 50 cycles, then all ones.
  - Exactly one key_valid, 6 cycles after the first stable edge, with key_code=3.
  - key_held high until 4 clean NONE samples.
- Press bounce: digit 7 toggled low/high every 2 cycles for 10 cycles, then held 20 cycles.
  - Exactly one key_valid, code 7, timed from the final stable low.
- Release bounce: after digit 5 is accepted, release, then re-press 2 cycles later, then release cleanly.
  - No second key_valid.
  - key_held stays 1 until the clean release completes.
- Multi-key: digits 1 and 2 low together for 30 cycles, then release.
  - One key_err pulse, zero key_valid.
  - A subsequent press of digit 9 after DEBOUNCE_CYC idle is accepted, code 9.
- Auto-repeat, REPEAT_EN=1, REPEAT_DLY=10, REPEAT_RATE=5, DEBOUNCE_CYC=4: hold digit 0 for 40 cycles.
  - key_valid at initial, +10, +15, +20, +25, +30, +35 cycles, all with code 0.
- Reset mid-debounce: assert rst for 1 cycle while in PRESS_DEB with digit 4 held.
  - No pulse around the reset.
  - key_valid with code 4 exactly DEBOUNCE_CYC+2 cycles after rst deasserts.
